pcie_tx_seg_packer: RTL

- Parametrised next-generation TX aligner between AFU TX AXI-S and the PCIe TX bridge.
- Input beats carry NUM_CH TLP segments, which may contain arbitrary idle holes.
- The block compacts them through a segment buffer and emits beats whose valid segments are a contiguous prefix from ch0.
- A multi-segment TLP is never split by an idle segment or an idle cycle.

---
 rtl/pcie_tx_seg_packer_pkg.sv | 41 ++++
 rtl/pcie_tx_seg_packer_compactor.sv | 49 ++++
 rtl/pcie_tx_seg_packer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_tx_seg_packer_pkg.sv
// ---------------------------------------------------------------------------
// pcie_tx_seg_pkg
// Shared types and helpers for the PCIe TX segment packer.
//   t_tx_seg     : reference per-segment layout at the default widths
//   popcount_ch  : number of set bits in a per-channel mask (up to 8 channels)
//   ptr_w/cnt_w  : segment buffer pointer / occupancy counter widths
// ---------------------------------------------------------------------------
package pcie_tx_seg_pkg;

    localparam int P_NUM_CH_MAX  = 8;
    localparam int P_SEG_W_DFLT  = 256;
    localparam int P_USER_W_DFLT = 10;

    typedef struct packed {
        logic                     valid;
        logic                     sop;
        logic                     eop;
        logic [P_USER_W_DFLT-1:0] user;
        logic [P_SEG_W_DFLT-1:0]  data;
    } t_tx_seg;

    // Read/write pointer width for a buffer of 'depth' entries.
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy counter width: one extra bit so "full" is representable.
    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

    function automatic logic [3:0] popcount_ch(input logic [P_NUM_CH_MAX-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < P_NUM_CH_MAX; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pcie_tx_seg_packer_compactor.sv
// ---------------------------------------------------------------------------
// pcie_tx_seg_compactor
// Combinational prefix-sum compaction: valid entries are moved down to a
// contiguous prefix starting at slot 0, keeping ascending channel order.
//   i_valid [NUM_CH]        : per-channel valid mask
//   i_ent   [NUM_CH*ENT_W]  : per-channel entries, ch0 in LSBs
//   o_valid [NUM_CH]        : compacted valid mask (always a prefix)
//   o_ent   [NUM_CH*ENT_W]  : compacted entries, unused slots zero
// ---------------------------------------------------------------------------
module pcie_tx_seg_compactor
    import pcie_tx_seg_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ENT_W  = 8
) (
    input  logic [NUM_CH-1:0]       i_valid,
    input  logic [NUM_CH*ENT_W-1:0] i_ent,
    output logic [NUM_CH-1:0]       o_valid,
    output logic [NUM_CH*ENT_W-1:0] o_ent
);

    localparam int IW = $clog2(NUM_CH) + 1;

    // w_pre[c] = number of valid channels below c = destination slot of c
    logic [IW-1:0] w_pre [NUM_CH];

    assign w_pre[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_CH; gi++) begin : g_prefix
            assign w_pre[gi] = w_pre[gi-1] + IW'(i_valid[gi-1]);
        end
    endgenerate

    always_comb begin
        o_valid = '0;
        o_ent   = '0;
        for (int s = 0; s < NUM_CH; s++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (i_valid[c] && (w_pre[c] == IW'(s))) begin
                    o_valid[s]              = 1'b1;
                    o_ent[s*ENT_W +: ENT_W] = i_ent[c*ENT_W +: ENT_W];
                end
            end
        end
    end

endmodule

// File: rtl/pcie_tx_seg_packer.sv
// ---------------------------------------------------------------------------
// pcie_tx_seg_packer
// Compacts TLP segments arriving with idle holes into output beats whose
// valid segments are a contiguous prefix from ch0. A multi-segment TLP is
// held back until its eop is buffered or a full beat is available, so it is
// never split by an idle slot or an idle cycle.
//
// Ports
//   clk, rst_n                 : clock, synchronous active-low reset
//   i_tvalid / i_tready        : input beat handshake (i_tready registered)
//   i_seg_valid/sop/eop        : per-segment input flags
//   i_seg_data / i_seg_user    : per-segment payload / tuser, ch0 in LSBs
//   o_tvalid / o_tready        : output beat handshake
//   o_seg_valid/sop/eop        : packed output flags (valid is a prefix)
//   o_seg_data / o_seg_user    : packed payload / tuser
//   o_proto_err                : sticky TLP framing error
//
// Build option
//   PCIE_TX_SEG_PACKER_PROTO_CHK_EN : enables the input framing checker
//   driving o_proto_err; without it o_proto_err is constant 0.
// ---------------------------------------------------------------------------
module pcie_tx_seg_packer
    import pcie_tx_seg_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int SEG_W     = 256,
    parameter int USER_W    = 10,
    parameter int BUF_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_tvalid,
    output logic                     i_tready,
    input  logic [NUM_CH-1:0]        i_seg_valid,
    input  logic [NUM_CH-1:0]        i_seg_sop,
    input  logic [NUM_CH-1:0]        i_seg_eop,
    input  logic [NUM_CH*SEG_W-1:0]  i_seg_data,
    input  logic [NUM_CH*USER_W-1:0] i_seg_user,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic [NUM_CH-1:0]        o_seg_valid,
    output logic [NUM_CH-1:0]        o_seg_sop,
    output logic [NUM_CH-1:0]        o_seg_eop,
    output logic [NUM_CH*SEG_W-1:0]  o_seg_data,
    output logic [NUM_CH*USER_W-1:0] o_seg_user,
    output logic                     o_proto_err
);

    localparam int PW    = ptr_w(BUF_DEPTH);
    localparam int CW    = cnt_w(BUF_DEPTH);
    // Buffer entry: {sop, eop, user, data}; only valid segments are stored.
    localparam int EW    = SEG_W + USER_W + 2;
    localparam int E_EOP = SEG_W + USER_W;
    localparam int E_SOP = SEG_W + USER_W + 1;

    generate
        if (NUM_CH != 1 && NUM_CH != 2 && NUM_CH != 4 && NUM_CH != 8) begin : g_bad_num_ch
            $error("pcie_tx_seg_packer: NUM_CH must be 1, 2, 4 or 8");
        end
        if (BUF_DEPTH < 2*NUM_CH || (BUF_DEPTH & (BUF_DEPTH-1)) != 0) begin : g_bad_depth
            $error("pcie_tx_seg_packer: BUF_DEPTH must be a power of 2 and >= 2*NUM_CH");
        end
    endgenerate

    logic [EW-1:0]            r_mem [BUF_DEPTH];
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic [NUM_CH-1:0]        r_out_vmask;
    logic [NUM_CH-1:0]        r_out_sop;
    logic [NUM_CH-1:0]        r_out_eop;
    logic [NUM_CH*SEG_W-1:0]  r_out_data;
    logic [NUM_CH*USER_W-1:0] r_out_user;

    logic [NUM_CH*EW-1:0]     w_in_ent;
    logic [NUM_CH*EW-1:0]     w_cmp_ent;
    logic [NUM_CH-1:0]        w_cmp_valid;
    logic                     w_accept;
    logic [CW-1:0]            w_push_n;
    logic [PW-1:0]            w_wr_idx [NUM_CH];
    logic [PW-1:0]            w_rd_idx [NUM_CH];
    logic [EW-1:0]            w_head   [NUM_CH];
    logic [NUM_CH-1:0]        w_cand_eop;
    logic [NUM_CH-1:0]        w_head_sop;
    logic [NUM_CH-1:0]        w_head_eop;
    logic [NUM_CH*SEG_W-1:0]  w_head_data;
    logic [NUM_CH*USER_W-1:0] w_head_user;
    logic [NUM_CH-1:0]        w_pop_mask;
    logic [CW-1:0]            w_pop_n;
    logic [CW-1:0]            w_pop_eff;
    logic                     w_load;
    logic [CW-1:0]            w_count_next;

    // ---------------- input side: compaction and push ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_in
            assign w_in_ent[gi*EW +: EW] = {i_seg_sop[gi], i_seg_eop[gi],
                                            i_seg_user[gi*USER_W +: USER_W],
                                            i_seg_data[gi*SEG_W +: SEG_W]};
            assign w_wr_idx[gi] = r_wr_ptr + PW'(gi);
        end
    endgenerate

    pcie_tx_seg_compactor #(
        .NUM_CH (NUM_CH),
        .ENT_W  (EW)
    ) u_in_cmp (
        .i_valid (i_seg_valid),
        .i_ent   (w_in_ent),
        .o_valid (w_cmp_valid),
        .o_ent   (w_cmp_ent)
    );

    assign w_accept = i_tvalid && r_in_ready;
    assign w_push_n = w_accept ? CW'(popcount_ch(P_NUM_CH_MAX'(i_seg_valid))) : '0;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_cmp_valid[k]) begin
                    r_mem[w_wr_idx[k]] <= w_cmp_ent[k*EW +: EW];
                end
            end
        end
    end

    // ---------------- output side: head candidates and emission ----------------
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_head
            assign w_rd_idx[gi]   = r_rd_ptr + PW'(gi);
            assign w_head[gi]     = r_mem[w_rd_idx[gi]];
            // Entries at or beyond count are stale and must not trigger emission.
            assign w_cand_eop[gi] = (CW'(gi) < r_count) && w_head[gi][E_EOP];
            assign w_head_sop[gi] = w_head[gi][E_SOP];
            assign w_head_eop[gi] = w_head[gi][E_EOP];
            assign w_head_data[gi*SEG_W +: SEG_W]   = w_head[gi][SEG_W-1:0];
            assign w_head_user[gi*USER_W +: USER_W] = w_head[gi][SEG_W +: USER_W];
            assign w_pop_mask[gi] = (CW'(gi) < w_pop_n);
        end
    endgenerate

    // Full beat when enough segments are buffered; otherwise emit up to the
    // highest buffered eop so an unfinished TLP tail stays behind.
    always_comb begin
        w_pop_n = '0;
        if (r_count >= CW'(NUM_CH)) begin
            w_pop_n = CW'(NUM_CH);
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_cand_eop[k]) begin
                    w_pop_n = CW'(k + 1);
                end
            end
        end
    end

    assign w_load       = !r_out_valid || o_tready;
    assign w_pop_eff    = w_load ? w_pop_n : '0;
    assign w_count_next = r_count + w_push_n - w_pop_eff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_vmask <= '0;
            r_out_sop   <= '0;
            r_out_eop   <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + w_push_n[PW-1:0];
            r_rd_ptr   <= r_rd_ptr + w_pop_eff[PW-1:0];
            r_count    <= w_count_next;
            // Room for a whole worst-case beat after this cycle's push/pop.
            r_in_ready <= (CW'(BUF_DEPTH) - w_count_next) >= CW'(NUM_CH);
            if (w_load) begin
                r_out_valid <= (w_pop_n != '0);
                r_out_vmask <= w_pop_mask;
                r_out_sop   <= w_head_sop & w_pop_mask;
                r_out_eop   <= w_head_eop & w_pop_mask;
            end
        end
    end

    // Payload needs no reset; the masks above qualify it.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_out_data <= w_head_data;
            r_out_user <= w_head_user;
        end
    end

    assign i_tready    = r_in_ready;
    assign o_tvalid    = r_out_valid;
    assign o_seg_valid = r_out_vmask;
    assign o_seg_sop   = r_out_sop;
    assign o_seg_eop   = r_out_eop;
    assign o_seg_data  = r_out_data;
    assign o_seg_user  = r_out_user;

    // ---------------- optional framing checker ----------------
`ifdef PCIE_TX_SEG_PACKER_PROTO_CHK_EN
    logic r_tlp_open;
    logic r_proto_err;
    logic w_open_next;
    logic w_err_hit;

    always_comb begin
        w_open_next = r_tlp_open;
        w_err_hit   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_seg_valid[k]) begin
                // sop while open, or continuation while closed, are both sop==open.
                if (i_seg_sop[k] == w_open_next) begin
                    w_err_hit = 1'b1;
                end
                if (i_seg_sop[k]) begin
                    w_open_next = !i_seg_eop[k];
                end else if (i_seg_eop[k]) begin
                    w_open_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tlp_open  <= 1'b0;
            r_proto_err <= 1'b0;
        end else if (w_accept) begin
            r_tlp_open <= w_open_next;
            if (w_err_hit) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign o_proto_err = r_proto_err;
`else
    assign o_proto_err = 1'b0;
`endif

endmodule
